// File: rtl/fifo_burst_scheduler.sv
// Write-side scheduler that shares one FIFO among NREQ producers in atomic bursts.
// Each burst matches the aggregator fetch width; width changes wait out a drain gap.
module fifo_burst_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int NREQ         = 2,
  parameter int FW_WIDTH     = 3,
  parameter int INIT_FW      = 2,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                       wclk,
  input  logic                       wrst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic [NREQ*FW_WIDTH-1:0]   req_fw,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       fifo_full_n,
  output logic                       fifo_enq,
  output logic [DATA_WIDTH-1:0]      fifo_din,
  output logic [FW_WIDTH-1:0]        fetch_width,
  output logic                       fw_toggle,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       busy
);

  localparam int GW  = $clog2(NREQ);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t              r_state;
  logic [GW-1:0]       r_grant;
  logic [FW_WIDTH-1:0] r_len;
  logic [FW_WIDTH-1:0] r_word_cnt;
  logic [DCW-1:0]      r_drain_cnt;
  logic [FW_WIDTH-1:0] r_fetch_width;
  logic                r_fw_toggle;

  logic                w_any;
  logic [GW-1:0]       w_pick;
  logic [FW_WIDTH-1:0] w_pick_fw;
  logic [FW_WIDTH-1:0] w_pick_len;
  logic                w_last_word;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NREQ;
    return s[GW-1:0];
  endfunction

  // Round-robin: scan from the farthest offset down so the requester closest to
  // grant_id+1 is the last one written and therefore wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_grant;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[rr_idx(r_grant, k)]) begin
        w_any  = 1'b1;
        w_pick = rr_idx(r_grant, k);
      end
    end
  end

  assign w_pick_fw   = req_fw[int'(w_pick)*FW_WIDTH +: FW_WIDTH];
  assign w_pick_len  = (w_pick_fw == '0) ? FW_WIDTH'(1) : w_pick_fw;
  assign w_last_word = (r_word_cnt == r_len - FW_WIDTH'(1));

  // Grant datapath; gated by reset so an abandoned burst cannot write on the reset edge.
  always_comb begin
    req_ready = '0;
    fifo_enq  = 1'b0;
    fifo_din  = req_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
    if (r_state == BURST && wrst_n) begin
      req_ready[r_grant] = fifo_full_n;
      fifo_enq           = req_valid[r_grant] & fifo_full_n;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_state       <= IDLE;
      r_grant       <= GW'(NREQ - 1);
      r_len         <= FW_WIDTH'(INIT_FW);
      r_word_cnt    <= '0;
      r_drain_cnt   <= '0;
      r_fetch_width <= FW_WIDTH'(INIT_FW);
      r_fw_toggle   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_len   <= w_pick_len;
            if (w_pick_len == r_fetch_width) begin
              r_state <= BURST;
            end else begin
              r_state     <= DRAIN;
              r_drain_cnt <= DCW'(DRAIN_CYCLES);
            end
          end
        end
        DRAIN: begin
          r_drain_cnt <= r_drain_cnt - DCW'(1);
          if (r_drain_cnt <= DCW'(1)) begin
            r_fetch_width <= r_len;
            r_fw_toggle   <= ~r_fw_toggle;
            r_state       <= BURST;
          end
        end
        BURST: begin
          if (fifo_enq) begin
            if (w_last_word) begin
              r_word_cnt <= '0;
              r_state    <= IDLE;
            end else begin
              r_word_cnt <= r_word_cnt + FW_WIDTH'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fetch_width = r_fetch_width;
  assign fw_toggle   = r_fw_toggle;
  assign grant_id    = r_grant;
  assign busy        = (r_state != IDLE);

  // Structural invariants of the grant path.
  a_ready_onehot: assert property (@(posedge wclk) disable iff (!wrst_n) $onehot0(req_ready));
  a_enq_in_burst: assert property (@(posedge wclk) disable iff (!wrst_n) fifo_enq |-> (r_state == BURST));
  a_enq_full_n:   assert property (@(posedge wclk) disable iff (!wrst_n) fifo_enq |-> fifo_full_n);

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// Directed bench for fifo_burst_scheduler: reset, width match, width change,
// contention, backpressure and reset mid-burst.
module tb_fifo_burst_scheduler;

  logic        wclk;
  logic        wrst_n;
  logic [1:0]  req_valid;
  logic [7:0]  d0, d1;
  logic [2:0]  f0, f1;
  logic [15:0] req_data;
  logic [5:0]  req_fw;
  logic [1:0]  req_ready;
  logic        fifo_full_n;
  logic        fifo_enq;
  logic [7:0]  fifo_din;
  logic [2:0]  fetch_width;
  logic        fw_toggle;
  logic [0:0]  grant_id;
  logic        busy;

  int vectors;
  int miscompares;
  logic [7:0] enq_q[$];
  logic [0:0] gid_q[$];
  int done;

  assign req_data = {d1, d0};
  assign req_fw   = {f1, f0};

  fifo_burst_scheduler #(
    .DATA_WIDTH(8), .NREQ(2), .FW_WIDTH(3), .INIT_FW(2), .DRAIN_CYCLES(8)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_fw(req_fw), .req_ready(req_ready), .fifo_full_n(fifo_full_n),
    .fifo_enq(fifo_enq), .fifo_din(fifo_din), .fetch_width(fetch_width),
    .fw_toggle(fw_toggle), .grant_id(grant_id), .busy(busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  // Record every FIFO write mid-cycle, when inputs and state are stable.
  always @(negedge wclk) begin
    if (fifo_enq === 1'b1) begin
      enq_q.push_back(fifo_din);
      gid_q.push_back(grant_id);
      vectors++;
      assert (fifo_full_n === 1'b1) else begin
        miscompares++;
        $error("FAIL enq_while_full: observed full_n=%0b expected 1", fifo_full_n);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; done = 0;
    wrst_n = 1'b0; req_valid = '0; d0 = '0; d1 = '0; f0 = '0; f1 = '0;
    fifo_full_n = 1'b1;

    // 1: reset
    repeat (5) nxt();
    chk("rst_fetch_width", 32'(fetch_width), 32'd2);
    chk("rst_fw_toggle",   32'(fw_toggle),   32'd0);
    chk("rst_fifo_enq",    32'(fifo_enq),    32'd0);
    chk("rst_busy",        32'(busy),        32'd0);
    chk("rst_grant_id",    32'(grant_id),    32'd1);

    // 2: width match, req0 fw=2
    wrst_n = 1'b1; req_valid = 2'b01; f0 = 3'd2; d0 = 8'd1;
    nxt();
    chk("m_busy",  32'(busy),     32'd1);
    chk("m_grant", 32'(grant_id), 32'd0);
    chk("m_enq0",  32'(fifo_enq), 32'd1);
    chk("m_din0",  32'(fifo_din), 32'd1);
    chk("m_ready", 32'(req_ready), 32'd1);
    nxt();
    d0 = 8'd2; #1;
    chk("m_enq1", 32'(fifo_enq), 32'd1);
    chk("m_din1", 32'(fifo_din), 32'd2);
    nxt();
    req_valid = 2'b00; #1;
    chk("m_idle_busy", 32'(busy),        32'd0);
    chk("m_idle_enq",  32'(fifo_enq),    32'd0);
    chk("m_toggle",    32'(fw_toggle),   32'd0);
    chk("m_fw",        32'(fetch_width), 32'd2);

    // 3: width change, req1 fw=4
    nxt();
    req_valid = 2'b10; f1 = 3'd4; d1 = 8'd10;
    nxt();
    chk("w_busy",  32'(busy),      32'd1);
    chk("w_grant", 32'(grant_id),  32'd1);
    chk("w_enq",   32'(fifo_enq),  32'd0);
    chk("w_ready", 32'(req_ready), 32'd0);
    for (int i = 1; i < 8; i++) begin
      nxt();
      chk("w_drain_enq", 32'(fifo_enq),    32'd0);
      chk("w_drain_fw",  32'(fetch_width), 32'd2);
    end
    nxt();
    chk("w_fw4",    32'(fetch_width), 32'd4);
    chk("w_toggle", 32'(fw_toggle),   32'd1);
    chk("w_enq0",   32'(fifo_enq),    32'd1);
    chk("w_din0",   32'(fifo_din),    32'd10);
    for (int i = 1; i < 4; i++) begin
      nxt();
      d1 = 8'(10 + i); #1;
      chk("w_enq", 32'(fifo_enq), 32'd1);
      chk("w_din", 32'(fifo_din), 32'(10 + i));
    end
    nxt();
    req_valid = 2'b00; #1;
    chk("w_done_busy", 32'(busy), 32'd0);

    // 4: contention, both fw=4
    nxt();
    enq_q.delete(); gid_q.delete();
    req_valid = 2'b11; f0 = 3'd4; f1 = 3'd4; d0 = 8'hA0; d1 = 8'hB0;
    repeat (20) nxt();
    req_valid = 2'b00; #1;
    chk("c_count", 32'(enq_q.size()), 32'd16);
    for (int i = 0; i < enq_q.size() && i < 16; i++) begin
      chk("c_din",   32'(enq_q[i]), ((i / 4) % 2 == 0) ? 32'hA0 : 32'hB0);
      chk("c_grant", 32'(gid_q[i]), 32'((i / 4) % 2));
    end

    // 5: backpressure on a fw=4 burst from req0
    nxt();
    enq_q.delete(); gid_q.delete();
    req_valid = 2'b01; d0 = 8'hC5;
    nxt();
    for (int c = 0; c < 64; c++) begin
      fifo_full_n = 1'($urandom_range(0, 1));
      #1;
      if (!busy) begin
        req_valid = 2'b00;
        done = 1;
        break;
      end
      chk("b_grant_held", 32'(grant_id), 32'd0);
      nxt();
    end
    fifo_full_n = 1'b1;
    chk("b_finished", 32'(done), 32'd1);
    chk("b_count",    32'(enq_q.size()), 32'd4);

    // 6: reset after 2 of 4 words
    nxt();
    enq_q.delete(); gid_q.delete();
    req_valid = 2'b01; d0 = 8'hD0;
    repeat (3) nxt();
    chk("r_words_before", 32'(enq_q.size()), 32'd2);
    wrst_n = 1'b0;
    nxt();
    wrst_n = 1'b1;
    enq_q.delete(); gid_q.delete();
    #1;
    chk("r_busy",   32'(busy),        32'd0);
    chk("r_fw",     32'(fetch_width), 32'd2);
    chk("r_toggle", 32'(fw_toggle),   32'd0);
    chk("r_grant",  32'(grant_id),    32'd1);
    chk("r_enq",    32'(fifo_enq),    32'd0);
    for (int i = 0; i < 8; i++) begin
      nxt();
      chk("r_no_enq", 32'(fifo_enq), 32'd0);
    end
    chk("r_drain_busy", 32'(busy),          32'd1);
    chk("r_drain_fw",   32'(fetch_width),   32'd2);
    chk("r_no_words",   32'(enq_q.size()),  32'd0);
    req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
